// File: rtl/sonic_vc_tx_pkg.sv
// Shared definitions for the VC TX arbiter and the TX FIFO it feeds.
//   state_e     : arbiter FSM states (ARB = choosing a packet, PKT = forwarding it)
//   sink_beat_t : 133-bit beat bundle {sop, eop, empty, error, data}
package sonic_vc_tx_pkg;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned EMPTY_W = 2;

    typedef enum logic [0:0] {
        ARB = 1'b0,
        PKT = 1'b1
    } state_e;

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               error;
        logic [DATA_W-1:0]  data;
    } sink_beat_t;

    localparam int unsigned BEAT_W = $bits(sink_beat_t);

endpackage

// File: rtl/sonic_vc_rr_pick.sv
// Combinational rotate-priority picker.
//   req        : request mask, one bit per port
//   last_grant : previously granted port; search starts at last_grant+1
//   winner     : first requesting port found, wrapping modulo NUM_PORTS
//   any_valid  : at least one request present
module sonic_vc_rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic [PORT_W-1:0]    winner,
    output logic                 any_valid
);
    import sonic_vc_tx_pkg::*;

    always_comb begin
        int unsigned idx;
        logic [PORT_W-1:0] sel;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        // k = NUM_PORTS wraps back to last_grant itself, so it is searched last.
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            sel = PORT_W'(idx);
            if (!any_valid && req[sel]) begin
                any_valid = 1'b1;
                winner    = sel;
            end
        end
    end

endmodule

// File: rtl/sonic_vc_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS Avalon-ST VC TX streams
// into one TX FIFO sink.
//   wrclock, reset_n       : clock, asynchronous active-low reset
//   port_en                : per-port arbitration enable (looked at only in ARB)
//   sink_*                 : per-port input streams, ready latency 0
//   source_*               : registered output stream, FIFO ready latency 1
//   grant_port, busy       : current/last grant, high while forwarding a packet
//   drop_count             : saturating count of discarded orphan beats
module sonic_vc_tx_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned EMPTY_W   = 2,
    parameter int unsigned PORT_W    = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         wrclock,
    input  logic                         reset_n,
    input  logic [NUM_PORTS-1:0]         port_en,
    input  logic [NUM_PORTS*DATA_W-1:0]  sink_data,
    input  logic [NUM_PORTS*EMPTY_W-1:0] sink_empty,
    input  logic [NUM_PORTS-1:0]         sink_startofpacket,
    input  logic [NUM_PORTS-1:0]         sink_endofpacket,
    input  logic [NUM_PORTS-1:0]         sink_error,
    input  logic [NUM_PORTS-1:0]         sink_valid,
    output logic [NUM_PORTS-1:0]         sink_ready,
    output logic [DATA_W-1:0]            source_data,
    output logic [EMPTY_W-1:0]           source_empty,
    output logic                         source_startofpacket,
    output logic                         source_endofpacket,
    output logic                         source_error,
    output logic                         source_valid,
    input  logic                         source_ready,
    output logic [PORT_W-1:0]            grant_port,
    output logic                         busy,
    output logic [CNT_W-1:0]             drop_count
);
    import sonic_vc_tx_pkg::*;

    state_e               state_q, state_d;
    logic [PORT_W-1:0]    grant_q, grant_d;
    logic [PORT_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [EMPTY_W-1:0]   empty_q, empty_d;
    logic                 sop_q, sop_d, eop_q, eop_d, err_q, err_d, valid_q, valid_d;

    logic [NUM_PORTS-1:0] cand, drain, ready_c;
    logic [PORT_W-1:0]    winner;
    logic                 any_cand;
    logic [3:0]           n_drain;
    logic [CNT_W+3:0]     drop_sum;

    // Beat currently presented by the granted port.
    logic                 g_valid, g_sop, g_eop, g_err;
    logic [EMPTY_W-1:0]   g_empty;
    logic [DATA_W-1:0]    g_data;

    sonic_vc_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req        (cand),
        .last_grant (last_q),
        .winner     (winner),
        .any_valid  (any_cand)
    );

    always_comb begin
        g_valid = 1'b0;
        g_sop   = 1'b0;
        g_eop   = 1'b0;
        g_err   = 1'b0;
        g_empty = '0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PORT_W'(i)) begin
                g_valid = sink_valid[i];
                g_sop   = sink_startofpacket[i];
                g_eop   = sink_endofpacket[i];
                g_err   = sink_error[i];
                g_empty = sink_empty[i*EMPTY_W +: EMPTY_W];
                g_data  = sink_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        cand     = port_en & sink_valid & sink_startofpacket;
        drain    = port_en & sink_valid & ~sink_startofpacket;
        ready_c  = '0;
        n_drain  = '0;
        drop_sum = '0;
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        drop_d   = drop_q;
        data_d   = data_q;
        empty_d  = empty_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        err_d    = err_q;
        valid_d  = 1'b0;

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            n_drain = n_drain + {3'b000, drain[i]};
        end

        case (state_q)
            ARB: begin
                // Orphans are swallowed in the same cycle a winner is chosen.
                ready_c  = drain;
                drop_sum = (CNT_W+4)'(drop_q) + (CNT_W+4)'(n_drain);
                if (drop_sum[CNT_W+3:CNT_W] != '0) begin
                    drop_d = '1;
                end else begin
                    drop_d = drop_sum[CNT_W-1:0];
                end
                if (any_cand) begin
                    grant_d = winner;
                    state_d = PKT;
                end
            end
            PKT: begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == PORT_W'(i)) begin
                        ready_c[i] = source_ready;
                    end
                end
                if (g_valid && source_ready) begin
                    valid_d = 1'b1;
                    data_d  = g_data;
                    empty_d = g_empty;
                    sop_d   = g_sop;
                    eop_d   = g_eop;
                    err_d   = g_err;
                    if (g_eop) begin
                        last_d  = grant_q;
                        state_d = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Ready is forced low while reset is held so nothing is consumed upstream.
    assign sink_ready = ready_c & {NUM_PORTS{reset_n}};

    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
            grant_q <= '0;
            last_q  <= PORT_W'(NUM_PORTS - 1);
            drop_q  <= '0;
            data_q  <= '0;
            empty_q <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            empty_q <= empty_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign source_data          = data_q;
    assign source_empty         = empty_q;
    assign source_startofpacket = sop_q;
    assign source_endofpacket   = eop_q;
    assign source_error         = err_q;
    assign source_valid         = valid_q;
    assign grant_port           = grant_q;
    assign busy                 = (state_q == PKT);
    assign drop_count           = drop_q;

endmodule

// File: tb/tb_sonic_vc_tx_arbiter.sv
// Self-checking bench for sonic_vc_tx_arbiter: directed scenarios plus
// randomized packet mixes checked against a packet-level round-robin model.
module tb_sonic_vc_tx_arbiter;
    import sonic_vc_tx_pkg::*;

    localparam int unsigned NP    = 4;
    localparam int unsigned DW    = 128;
    localparam int unsigned EW    = 2;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 4;
    localparam int unsigned TRMAX = 4096;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     port_en;
    logic [NP*DW-1:0]  sink_data;
    logic [NP*EW-1:0]  sink_empty;
    logic [NP-1:0]     sink_sop, sink_eop, sink_error, sink_valid, sink_ready;
    logic [DW-1:0]     source_data;
    logic [EW-1:0]     source_empty;
    logic              source_sop, source_eop, source_error, source_valid, source_ready;
    logic [PW-1:0]     grant_port;
    logic              busy;
    logic [CW-1:0]     drop_count;

    sonic_vc_tx_arbiter #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .EMPTY_W   (EW),
        .PORT_W    (PW),
        .CNT_W     (CW)
    ) dut (
        .wrclock              (clk),
        .reset_n              (reset_n),
        .port_en              (port_en),
        .sink_data            (sink_data),
        .sink_empty           (sink_empty),
        .sink_startofpacket   (sink_sop),
        .sink_endofpacket     (sink_eop),
        .sink_error           (sink_error),
        .sink_valid           (sink_valid),
        .sink_ready           (sink_ready),
        .source_data          (source_data),
        .source_empty         (source_empty),
        .source_startofpacket (source_sop),
        .source_endofpacket   (source_eop),
        .source_error         (source_error),
        .source_valid         (source_valid),
        .source_ready         (source_ready),
        .grant_port           (grant_port),
        .busy                 (busy),
        .drop_count           (drop_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sink_beat_t  pq[NP][$];     // beats each port still has to present
    sink_beat_t  mq[NP][$];     // model copy of queued packets
    int unsigned ml[NP][$];     // model copy of packet lengths
    sink_beat_t  exp_q[$];      // expected output beats, in order
    logic        busy_tr[TRMAX];
    logic        val_tr[TRMAX];
    int unsigned cyc, last_acc_cyc;
    int unsigned sr_lo, sr_hi, en_lo, en_hi;
    bit          rand_ready;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic sink_beat_t make_beat(input logic sop, input logic eop);
        sink_beat_t b;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = EW'($urandom_range(0, 3));
        b.error = 1'($urandom_range(0, 1));
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    // Queue a packet on a port; optionally record it for the RR model.
    task automatic add_pkt(input int unsigned p, input int unsigned len, input bit to_exp, input bit to_model);
        sink_beat_t b;
        for (int unsigned j = 0; j < len; j++) begin
            b = make_beat(j == 0, j == len - 1);
            pq[p].push_back(b);
            if (to_exp)   exp_q.push_back(b);
            if (to_model) mq[p].push_back(b);
        end
        if (to_model) ml[p].push_back(len);
    endtask

    task automatic add_orphans(input int unsigned p, input int unsigned n);
        for (int unsigned j = 0; j < n; j++) pq[p].push_back(make_beat(1'b0, 1'b0));
    endtask

    // Packet-level round robin: next port after the last one served that
    // still has a packet waiting, each packet sent whole.
    task automatic build_exp();
        int unsigned last = NP - 1;
        bit found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int unsigned k = 1; k <= NP && !found; k++) begin
                int unsigned p = (last + k) % NP;
                if (ml[p].size() > 0) begin
                    int unsigned len = ml[p].pop_front();
                    for (int unsigned j = 0; j < len; j++) exp_q.push_back(mq[p].pop_front());
                    last  = p;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_inputs();
        sink_valid = '0; sink_sop = '0; sink_eop = '0; sink_error = '0;
        sink_data = '0; sink_empty = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (pq[i].size() > 0) begin
                sink_valid[i]            = 1'b1;
                sink_sop[i]              = pq[i][0].sop;
                sink_eop[i]              = pq[i][0].eop;
                sink_error[i]            = pq[i][0].error;
                sink_empty[i*EW +: EW]   = pq[i][0].empty;
                sink_data[i*DW +: DW]    = pq[i][0].data;
            end
        end
    endtask

    task automatic run_cycle();
        logic [NP-1:0] acc;
        sink_beat_t got;
        @(negedge clk);
        cyc++;
        drive_inputs();
        port_en = '1;
        if (cyc >= en_lo && cyc <= en_hi) port_en[1] = 1'b0;
        if (cyc >= sr_lo && cyc <= sr_hi) source_ready = 1'b0;
        else if (rand_ready)              source_ready = ($urandom_range(0, 3) != 0);
        else                              source_ready = 1'b1;
        #1;
        acc = sink_valid & sink_ready;
        if (acc != '0) last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < NP; i++) if (acc[i]) void'(pq[i].pop_front());
        if (cyc + 1 < TRMAX) begin
            busy_tr[cyc+1] = busy;
            val_tr[cyc+1]  = source_valid;
        end
        if (source_valid) begin
            got = {source_sop, source_eop, source_empty, source_error, source_data};
            if (exp_q.size() == 0) check_eq("unexpected_beat", 160'(got), '0);
            else                   check_eq("out_beat", 160'(got), 160'(exp_q.pop_front()));
        end
    endtask

    task automatic run_until_empty(input int unsigned budget);
        int unsigned n = 0;
        bit pending = 1'b1;
        while (pending && n < budget) begin
            run_cycle();
            n++;
            pending = (exp_q.size() > 0);
            for (int unsigned i = 0; i < NP; i++) if (pq[i].size() > 0) pending = 1'b1;
        end
        if (pending) check_eq("timeout", 1, 0);
        run_cycle();  // catch any stray trailing beat
    endtask

    task automatic clear_all();
        for (int unsigned i = 0; i < NP; i++) begin
            pq[i].delete(); mq[i].delete(); ml[i].delete();
        end
        exp_q.delete();
        drive_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_all();
        port_en = '1; source_ready = 1'b1;
        sr_lo = TRMAX; sr_hi = 0; en_lo = TRMAX; en_hi = 0; rand_ready = 1'b0;
        #1;
        check_eq("rst_valid", 160'(source_valid), 0);
        check_eq("rst_busy",  160'(busy), 0);
        check_eq("rst_grant", 160'(grant_port), 0);
        check_eq("rst_drop",  160'(drop_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0; last_acc_cyc = 0;
        for (int unsigned i = 0; i < TRMAX; i++) begin busy_tr[i] = 1'b0; val_tr[i] = 1'b0; end
    endtask

    int unsigned total;

    initial begin
        reset_n = 1'b0; port_en = '0; source_ready = 1'b0;
        drive_inputs();
        repeat (2) @(negedge clk);

        // Single 3-beat packet: bubble in cycle 1, busy 2-4, valid 3-5.
        do_reset();
        add_pkt(0, 3, 1'b1, 1'b0);
        for (int unsigned c = 1; c <= 7; c++) run_cycle();
        for (int unsigned c = 2; c <= 7; c++) begin
            check_eq($sformatf("t1_busy_c%0d", c),  160'(busy_tr[c]), 160'(c >= 2 && c <= 4));
            check_eq($sformatf("t1_valid_c%0d", c), 160'(val_tr[c]),  160'(c >= 3 && c <= 5));
        end
        check_eq("t1_left", 160'(exp_q.size()), 0);

        // Three 2-beat packets at once: order 0,1,2 in 9 cycles.
        do_reset();
        for (int unsigned p = 0; p < 3; p++) add_pkt(p, 2, 1'b1, 1'b0);
        run_until_empty(40);
        check_eq("t2_cycles", 160'(last_acc_cyc), 9);

        // source_ready low for cycles 4-7 inside a 6-beat packet.
        do_reset();
        add_pkt(0, 6, 1'b1, 1'b0);
        sr_lo = 4; sr_hi = 7;
        for (int unsigned c = 1; c <= 13; c++) run_cycle();
        for (int unsigned c = 2; c <= 13; c++)
            check_eq($sformatf("t3_valid_c%0d", c), 160'(val_tr[c]),
                     160'((c == 3) || (c == 4) || (c >= 9 && c <= 12)));
        check_eq("t3_left", 160'(exp_q.size()), 0);

        // Five orphans on port 3.
        do_reset();
        add_orphans(3, 5);
        run_until_empty(20);
        check_eq("t4_drop", 160'(drop_count), 5);
        check_eq("t4_busy", 160'(busy), 0);

        // Twenty orphans saturate a 4-bit counter.
        do_reset();
        add_orphans(3, 20);
        run_until_empty(40);
        check_eq("t5_drop_sat", 160'(drop_count), 15);

        // Reset in the middle of a packet, then priority restarts at port 0.
        do_reset();
        add_pkt(1, 1, 1'b1, 1'b0);
        run_until_empty(10);
        add_pkt(2, 4, 1'b0, 1'b0);
        exp_q.push_back(pq[2][0]);
        exp_q.push_back(pq[2][1]);
        for (int unsigned c = 0; c < 3; c++) run_cycle();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t6_valid", 160'(source_valid), 0);
        check_eq("t6_busy",  160'(busy), 0);
        check_eq("t6_grant", 160'(grant_port), 0);
        check_eq("t6_ready", 160'(sink_ready), 0);
        check_eq("t6_data",  160'(source_data), 0);
        check_eq("t6_sop",   160'(source_sop), 0);
        check_eq("t6_beats_before_reset", 160'(exp_q.size()), 0);
        clear_all();
        @(negedge clk);
        reset_n = 1'b1;
        add_pkt(0, 2, 1'b1, 1'b0);
        add_pkt(2, 2, 1'b1, 1'b0);
        run_until_empty(30);

        // Single-beat packets on port 1 with port_en[1] low for cycles 2-6.
        do_reset();
        add_pkt(1, 1, 1'b1, 1'b0);
        add_pkt(1, 1, 1'b1, 1'b0);
        en_lo = 2; en_hi = 6;
        for (int unsigned c = 1; c <= 10; c++) run_cycle();
        for (int unsigned c = 2; c <= 10; c++) begin
            check_eq($sformatf("t7_busy_c%0d", c),  160'(busy_tr[c]), 160'(c == 2 || c == 8));
            check_eq($sformatf("t7_valid_c%0d", c), 160'(val_tr[c]),  160'(c == 3 || c == 9));
        end
        check_eq("t7_drop", 160'(drop_count), 0);

        // Random packet mixes: first with ready held high (cycle count known),
        // then with random backpressure.
        for (int unsigned r = 0; r < 6; r++) begin
            do_reset();
            total = 0;
            rand_ready = (r >= 2);
            for (int unsigned p = 0; p < NP; p++) begin
                int unsigned np = $urandom_range(0, 3);
                for (int unsigned k = 0; k < np; k++) begin
                    int unsigned len = $urandom_range(1, 4);
                    add_pkt(p, len, 1'b0, 1'b1);
                    total += len + 1;
                end
            end
            build_exp();
            run_until_empty(1000);
            if (!rand_ready) check_eq($sformatf("rand%0d_cycles", r), 160'(last_acc_cyc), 160'(total));
            check_eq($sformatf("rand%0d_drop", r), 160'(drop_count), 0);
            check_eq($sformatf("rand%0d_idle", r), 160'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
